// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, completion and memory-port signals of the arbiter
interface mem_port_arbiter_if #(parameter int ADDR_L = 32, parameter int DATA_L = 32);
    logic              if_re;
    logic [ADDR_L-1:0] if_addr;
    logic              if_rack;
    logic [DATA_L-1:0] if_rdata;
    logic              ma_re;
    logic              ma_we;
    logic [1:0]        ma_rlen;
    logic [1:0]        ma_wlen;
    logic [ADDR_L-1:0] ma_raddr;
    logic [ADDR_L-1:0] ma_waddr;
    logic [DATA_L-1:0] ma_wdata;
    logic              ma_rack;
    logic              ma_wack;
    logic [DATA_L-1:0] ma_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_L-1:0] mem_addr;
    logic [DATA_L-1:0] mem_wdata;
    logic [DATA_L-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;
    modport slave (
        input  if_re, if_addr, ma_re, ma_we, ma_rlen, ma_wlen, ma_raddr, ma_waddr, ma_wdata, mem_rdata, mem_ready,
        output if_rack, if_rdata, ma_rack, ma_wack, ma_rdata, mem_en, mem_we, mem_len, mem_addr, mem_wdata, err
    );
    modport master (
        output if_re, if_addr, ma_re, ma_we, ma_rlen, ma_wlen, ma_raddr, ma_waddr, ma_wdata, mem_rdata, mem_ready,
        input  if_rack, if_rdata, ma_rack, ma_wack, ma_rdata, mem_en, mem_we, mem_len, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and MA with MA priority, IF anti-starvation and timeout
module mem_port_arbiter #(
    parameter int ADDR_L     = 32,
    parameter int DATA_L     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OWN_IF, OWN_MR, OWN_MW} owner_t;
    state_t            state, state_nx;
    owner_t            own, g_own;
    logic [SW-1:0]     scnt;
    logic [TW-1:0]     tcnt;
    logic              err_q, req, g_if, illegal, timeout, finish;
    logic [1:0]        g_len;
    logic [ADDR_L-1:0] g_addr;
    logic [DATA_L-1:0] rd_cap;
    // Pick the next owner, classify its request, and drive the state-derived outputs
    always_comb begin
        req      = bus.if_re || bus.ma_re || bus.ma_we;
        g_if     = bus.if_re && (scnt == SMAX || !(bus.ma_re || bus.ma_we));
        g_own    = g_if ? OWN_IF : bus.ma_we ? OWN_MW : OWN_MR;
        g_len    = g_if ? 2'b11 : bus.ma_we ? bus.ma_wlen : bus.ma_rlen;
        g_addr   = g_if ? bus.if_addr : bus.ma_we ? bus.ma_waddr : bus.ma_raddr;
        illegal  = g_len == 2'b10 || (g_len == 2'b01 && g_addr[0]) || (g_len == 2'b11 && g_addr[1:0] != 2'b00);
        timeout  = tcnt == TLAST && !bus.mem_ready;
        finish   = bus.mem_ready || timeout;
        rd_cap   = bus.mem_ready ? bus.mem_rdata : '0;
        state_nx = state == IDLE ? (req ? (illegal ? DONE : BUSY) : IDLE)
                 : state == BUSY ? (finish ? DONE : BUSY) : IDLE;
        bus.mem_en  = state == BUSY;
        bus.if_rack = state == DONE && own == OWN_IF;
        bus.ma_rack = state == DONE && own == OWN_MR;
        bus.ma_wack = state == DONE && own == OWN_MW;
        bus.err     = state == DONE && err_q;
    end
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Latch the granted transaction, run the starve/timeout counters and capture completion data
    always_ff @(posedge clk) begin
        if (rst) begin
            own           <= OWN_IF;
            err_q         <= 1'b0;
            scnt          <= '0;
            tcnt          <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_len   <= 2'b00;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.ma_rdata  <= '0;
        end else if (state == IDLE && req) begin
            own           <= g_own;
            err_q         <= illegal;
            tcnt          <= '0;
            scnt          <= (g_if || !bus.if_re) ? '0 : scnt + SW'(scnt != SMAX);
            bus.mem_we    <= g_own == OWN_MW;
            bus.mem_len   <= g_len;
            bus.mem_addr  <= g_addr;
            bus.mem_wdata <= g_own == OWN_MW ? bus.ma_wdata : '0;
            if (illegal && g_own == OWN_IF) bus.if_rdata <= '0;
            if (illegal && g_own == OWN_MR) bus.ma_rdata <= '0;
        end else if (state == BUSY) begin
            tcnt <= tcnt + 1'b1;
            if (finish) begin
                err_q <= timeout;
                if (own == OWN_IF) bus.if_rdata <= rd_cap;
                if (own == OWN_MR) bus.ma_rdata <= rd_cap;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;
    localparam int AL = 32, DL = 32, SM = 4, TO = 64;
    typedef struct packed {logic [1:0] ch; logic err; logic [31:0] data;} ack_t;
    typedef struct packed {logic we; logic [1:0] len; logic [31:0] addr; logic [31:0] wdata;} acc_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ack_t exp_ack[$];
    acc_t exp_acc[$];
    int   n_cmp = 0, n_fail = 0;
    int   wait_cyc = 0;
    bit   no_ready = 0, stray = 0;
    int   mr_left = 0, mw_left = 0, if_left = 0;
    mem_port_arbiter_if #(.ADDR_L(AL), .DATA_L(DL)) bus ();
    mem_port_arbiter #(.ADDR_L(AL), .DATA_L(DL), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    task automatic push_ack(logic [1:0] ch, logic e, logic [31:0] d);
        exp_ack.push_back({ch, e, d});
    endtask

    task automatic push_acc(logic we, logic [1:0] len, logic [31:0] a, logic [31:0] wd);
        exp_acc.push_back({we, len, a, wd});
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop each level request once its channel has been acked the requested number of times
    task automatic serve(int budget);
        int t = 0;
        while ((mr_left + mw_left + if_left) > 0 && t < budget) begin
            step(1);
            t++;
            if (bus.ma_rack && mr_left > 0) begin mr_left--; if (mr_left == 0) bus.ma_re = 0; else bus.ma_raddr += 4; end
            if (bus.ma_wack && mw_left > 0) begin mw_left--; if (mw_left == 0) bus.ma_we = 0; else bus.ma_waddr += 4; end
            if (bus.if_rack && if_left > 0) begin if_left--; if (if_left == 0) bus.if_re = 0; else bus.if_addr += 4; end
        end
        if ((mr_left + mw_left + if_left) != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL serve_budget: %0d requests still pending after %0d cycles, want 0", mr_left + mw_left + if_left, t);
            bus.ma_re = 0; bus.ma_we = 0; bus.if_re = 0;
            mr_left = 0; mw_left = 0; if_left = 0;
        end
    endtask

    task automatic single_read(logic [31:0] a);
        push_ack(2, 0, mem_val(a));
        push_acc(0, 2'b11, a, 0);
        bus.ma_re = 1; bus.ma_rlen = 2'b11; bus.ma_raddr = a;
        mr_left = 1;
        serve(20);
        step(1);
    endtask

    task automatic illegal_req(logic [1:0] ch, logic [1:0] len, logic [31:0] a);
        push_ack(ch, 1, 0);
        if (ch == 1) begin bus.if_re = 1; bus.if_addr = a; end
        else if (ch == 2) begin bus.ma_re = 1; bus.ma_rlen = len; bus.ma_raddr = a; end
        else begin bus.ma_we = 1; bus.ma_wlen = len; bus.ma_waddr = a; bus.ma_wdata = 32'hFFFF; end
        step(1);
        check("ill_ack_next_cycle", 32'(bus.if_rack | bus.ma_rack | bus.ma_wack), 1);
        check("ill_err", 32'(bus.err), 1);
        check("ill_mem_en", 32'(bus.mem_en), 0);
        bus.if_re = 0; bus.ma_re = 0; bus.ma_we = 0;
        step(2);
    endtask

    // Memory model: answers after wait_cyc BUSY cycles, garbage data otherwise, optional stray ready when idle
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready = 0;
        bus.mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_en) begin
                bus.mem_ready = !no_ready && cnt == wait_cyc;
                bus.mem_rdata = bus.mem_ready ? mem_val(bus.mem_addr) : 32'hBAD0BAD0;
                cnt++;
            end else begin
                cnt = 0;
                bus.mem_ready = stray;
                bus.mem_rdata = 32'h5555AAAA;
            end
        end
    end

    // Monitor: pops expected acks and memory accesses whenever the DUT presents them
    initial begin
        logic en_q;
        logic [1:0] ch;
        ack_t e;
        acc_t a;
        en_q = 0;
        forever begin
            @(negedge clk);
            ch = bus.if_rack ? 2'd1 : bus.ma_rack ? 2'd2 : bus.ma_wack ? 2'd3 : 2'd0;
            if (ch != 0 || bus.err) begin
                check("single_ack", 32'(bus.if_rack) + 32'(bus.ma_rack) + 32'(bus.ma_wack), 1);
                if (exp_ack.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ack: channel %0d err %b, want no ack", ch, bus.err);
                end else begin
                    e = exp_ack.pop_front();
                    check("ack_channel", 32'(ch), 32'(e.ch));
                    check("ack_err", 32'(bus.err), 32'(e.err));
                    if (e.ch == 1) check("if_rdata", bus.if_rdata, e.data);
                    if (e.ch == 2) check("ma_rdata", bus.ma_rdata, e.data);
                end
            end
            if (bus.mem_en && !en_q) begin
                if (exp_acc.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_access: mem_addr 0x%0h, want no access", bus.mem_addr);
                end else begin
                    a = exp_acc.pop_front();
                    check("mem_we", 32'(bus.mem_we), 32'(a.we));
                    check("mem_len", 32'(bus.mem_len), 32'(a.len));
                    check("mem_addr", bus.mem_addr, a.addr);
                    if (a.we) check("mem_wdata", bus.mem_wdata, a.wdata);
                end
            end
            en_q = bus.mem_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1);
    end

    initial begin
        int busy, t;
        bus.if_re = 0; bus.if_addr = 0; bus.ma_re = 0; bus.ma_we = 0; bus.ma_rlen = 0; bus.ma_wlen = 0;
        bus.ma_raddr = 0; bus.ma_waddr = 0; bus.ma_wdata = 0;
        step(3);
        check("rst_mem_en", 32'(bus.mem_en), 0);
        check("rst_acks_err", 32'({bus.if_rack, bus.ma_rack, bus.ma_wack, bus.err}), 0);
        check("rst_mem_we_len", 32'({bus.mem_we, bus.mem_len}), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_rdata", bus.if_rdata | bus.ma_rdata, 0);
        rst = 0;
        step(2);
        // Zero-wait MA word read: 2-cycle latency
        push_ack(2, 0, mem_val(32'h100));
        push_acc(0, 2'b11, 32'h100, 0);
        bus.ma_re = 1; bus.ma_rlen = 2'b11; bus.ma_raddr = 32'h100;
        step(1);
        check("t1_mem_en_n1", 32'(bus.mem_en), 1);
        check("t1_no_ack_n1", 32'(bus.ma_rack), 0);
        step(1);
        check("t1_ack_n2", 32'(bus.ma_rack), 1);
        check("t1_mem_en_low_done", 32'(bus.mem_en), 0);
        bus.ma_re = 0;
        step(2);
        // MA write and IF read together: write first, then IF, separated by an idle cycle
        wait_cyc = 2;
        push_ack(3, 0, 0);
        push_ack(1, 0, mem_val(32'h200));
        push_acc(1, 2'b01, 32'h104, 32'h1234);
        push_acc(0, 2'b11, 32'h200, 0);
        bus.ma_we = 1; bus.ma_wlen = 2'b01; bus.ma_waddr = 32'h104; bus.ma_wdata = 32'h1234;
        bus.if_re = 1; bus.if_addr = 32'h200;
        mw_left = 1; if_left = 1;
        serve(40);
        // Six MA reads with IF held: four MA grants, then IF, then the last two MA
        wait_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            push_ack(2, 0, mem_val(32'h300 + 4 * i));
            push_acc(0, 2'b11, 32'h300 + 4 * i, 0);
        end
        push_ack(1, 0, mem_val(32'h200));
        push_acc(0, 2'b11, 32'h200, 0);
        for (int i = 4; i < 6; i++) begin
            push_ack(2, 0, mem_val(32'h300 + 4 * i));
            push_acc(0, 2'b11, 32'h300 + 4 * i, 0);
        end
        bus.ma_re = 1; bus.ma_rlen = 2'b11; bus.ma_raddr = 32'h300;
        bus.if_re = 1; bus.if_addr = 32'h200;
        mr_left = 6; if_left = 1;
        serve(80);
        step(1);
        // Illegal and misaligned requests: immediate err+ack, no memory access, zero data
        stray = 1;
        illegal_req(2, 2'b01, 32'h101);
        illegal_req(2, 2'b10, 32'h100);
        illegal_req(2, 2'b11, 32'h102);
        illegal_req(1, 2'b11, 32'h206);
        illegal_req(3, 2'b01, 32'h103);
        stray = 0;
        // Timeout after 64 BUSY cycles returns zero data with err
        single_read(32'h120);
        no_ready = 1;
        push_ack(2, 1, 0);
        push_acc(0, 2'b11, 32'h100, 0);
        bus.ma_re = 1; bus.ma_rlen = 2'b11; bus.ma_raddr = 32'h100;
        busy = 0;
        t = 0;
        do begin
            step(1);
            t++;
            if (bus.mem_en) busy++;
        end while (!bus.ma_rack && t < 100);
        bus.ma_re = 0;
        check("t5_busy_cycles", busy, 64);
        step(1);
        check("t5_back_idle", 32'(bus.mem_en), 0);
        // Reset during BUSY drops the transaction with no ack
        push_acc(0, 2'b11, 32'h400, 0);
        bus.ma_re = 1; bus.ma_rlen = 2'b11; bus.ma_raddr = 32'h400;
        step(3);
        rst = 1;
        bus.ma_re = 0;
        step(1);
        check("t6_mem_en", 32'(bus.mem_en), 0);
        check("t6_acks_err", 32'({bus.if_rack, bus.ma_rack, bus.ma_wack, bus.err}), 0);
        check("t6_mem_we_len", 32'({bus.mem_we, bus.mem_len}), 0);
        check("t6_mem_addr", bus.mem_addr, 0);
        check("t6_rdata", bus.if_rdata | bus.ma_rdata, 0);
        rst = 0;
        no_ready = 0;
        step(3);
        single_read(32'h408);
        step(3);
        check("ack_queue_drained", exp_ack.size(), 0);
        check("access_queue_drained", exp_acc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
